// File: rtl/disp_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : disp_pkg
//  Description : Shared types and the round-robin pick helper for disp_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package disp_pkg;

    localparam int C_MAX_REQ   = 16;
    localparam int C_MAX_SRC_W = 4;

    // Default entry layout; the arbiter builds its own width-matched variant.
    typedef struct packed {
        logic [C_MAX_SRC_W-1:0] src;
        logic [15:0]            seq;
        logic [31:0]            msg;
    } disp_entry_t;

    // One-hot grant to the first eligible index at or after ptr, modulo n_req.
    function automatic logic [C_MAX_REQ-1:0] rr_pick(
        input logic [C_MAX_REQ-1:0]   eligible,
        input logic [C_MAX_SRC_W-1:0] ptr,
        input int                     n_req
    );
        logic [C_MAX_REQ-1:0]   w_grant;
        logic [C_MAX_SRC_W-1:0] w_idx_b;
        logic                   w_found;
        int                     w_idx;
        w_grant = '0;
        w_found = 1'b0;
        for (int k = 0; k < C_MAX_REQ; k++) begin
            w_idx = int'(ptr) + k;
            if (w_idx >= n_req) w_idx = w_idx - n_req;
            w_idx_b = C_MAX_SRC_W'(w_idx);
            if ((k < n_req) && !w_found && eligible[w_idx_b]) begin
                w_grant[w_idx_b] = 1'b1;
                w_found          = 1'b1;
            end
        end
        return w_grant;
    endfunction

endpackage
`default_nettype wire

// File: rtl/disp_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Interface   : disp_arbiter_if
//  Description : Requester-side and sink-side signals of the message arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface disp_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int MSG_W = 32,
    parameter int SEQ_W = 16,
    parameter int DEPTH = 4
);
    localparam int C_SRC_W = $clog2(N_REQ);
    localparam int C_CNT_W = $clog2(DEPTH) + 1;

    logic [N_REQ-1:0]            en_mask;
    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ-1:0][MSG_W-1:0] req_msg;
    logic [N_REQ-1:0]            req_ready;
    logic                        out_valid;
    logic                        out_ready;
    logic [C_SRC_W-1:0]          out_src;
    logic [SEQ_W-1:0]            out_seq;
    logic [MSG_W-1:0]            out_msg;
    logic [C_CNT_W-1:0]          count;

    modport master (
        output en_mask, req_valid, req_msg, out_ready,
        input  req_ready, out_valid, out_src, out_seq, out_msg, count
    );

    modport slave (
        input  en_mask, req_valid, req_msg, out_ready,
        output req_ready, out_valid, out_src, out_seq, out_msg, count
    );

endinterface
`default_nettype wire

// File: rtl/disp_arbiter_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : disp_fifo
//  Description : Synchronous FIFO of tagged entries, wrap-bit pointers.
//  Revision    : 1.0 - initial release
// ============================================================================
module disp_fifo
    import disp_pkg::*;
#(
    parameter type ENTRY_T = disp_entry_t,
    parameter int  DEPTH   = 4
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              push,
    input  wire logic              pop,
    input  wire ENTRY_T            wdata,
    output      ENTRY_T            rdata,
    output      logic              full,
    output      logic              empty,
    output      logic [$clog2(DEPTH):0] count
);

    localparam int C_AW = $clog2(DEPTH);

    logic [C_AW:0] r_wr_ptr;
    logic [C_AW:0] r_rd_ptr;
    ENTRY_T        r_mem [DEPTH];
    logic          w_push_en;
    logic          w_pop_en;

    assign w_push_en = push & ~full;
    assign w_pop_en  = pop & ~empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_en) r_wr_ptr <= r_wr_ptr + (C_AW+1)'(1);
            if (w_pop_en)  r_rd_ptr <= r_rd_ptr + (C_AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_en) r_mem[r_wr_ptr[C_AW-1:0]] <= wdata;
    end

    assign full  = (r_wr_ptr[C_AW] != r_rd_ptr[C_AW]) &&
                   (r_wr_ptr[C_AW-1:0] == r_rd_ptr[C_AW-1:0]);
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign count = r_wr_ptr - r_rd_ptr;
    // Head is forced to zero when empty so the outputs are defined after reset.
    assign rdata = empty ? ENTRY_T'('0) : r_mem[r_rd_ptr[C_AW-1:0]];

endmodule
`default_nettype wire

// File: rtl/disp_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : disp_arbiter
//  Description : Round-robin arbiter tagging monitor messages into one sink.
//  Revision    : 1.0 - initial release
// ============================================================================
module disp_arbiter
    import disp_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int MSG_W = 32,
    parameter int SEQ_W = 16,
    parameter int DEPTH = 4
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    disp_arbiter_if.slave disp
);

    localparam int C_SRC_W = $clog2(N_REQ);

    typedef struct packed {
        logic [C_SRC_W-1:0] src;
        logic [SEQ_W-1:0]   seq;
        logic [MSG_W-1:0]   msg;
    } entry_t;

    logic [C_SRC_W-1:0]     r_rr_ptr;
    logic [SEQ_W-1:0]       r_seq_cnt;
    logic [N_REQ-1:0]       w_eligible;
    logic [N_REQ-1:0]       w_pick;
    logic [N_REQ-1:0]       w_grant;
    logic [C_MAX_REQ-1:0]   w_elig_ext;
    logic [C_MAX_SRC_W-1:0] w_ptr_ext;
    logic [C_SRC_W-1:0]     w_grant_idx;
    logic                   w_accept;
    logic                   w_full;
    logic                   w_empty;
    entry_t                 w_push_entry;
    entry_t                 w_head;

    always_comb begin
        w_eligible = disp.req_valid & disp.en_mask;
        w_elig_ext = '0;
        w_elig_ext[N_REQ-1:0] = w_eligible;
        w_ptr_ext  = '0;
        w_ptr_ext[C_SRC_W-1:0] = r_rr_ptr;
        w_pick     = N_REQ'(rr_pick(w_elig_ext, w_ptr_ext, N_REQ));
        // Held at zero while in reset and whenever the FIFO is full.
        w_grant    = (rst_n && !w_full) ? w_pick : '0;
        w_accept   = |w_grant;
        w_grant_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant[i]) w_grant_idx = C_SRC_W'(i);
        end
        w_push_entry.src = w_grant_idx;
        w_push_entry.seq = r_seq_cnt;
        w_push_entry.msg = disp.req_msg[w_grant_idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr  <= '0;
            r_seq_cnt <= '0;
        end else if (w_accept) begin
            r_rr_ptr  <= (w_grant_idx == C_SRC_W'(N_REQ-1)) ? '0
                                                            : w_grant_idx + C_SRC_W'(1);
            r_seq_cnt <= r_seq_cnt + SEQ_W'(1);
        end
    end

    disp_fifo #(
        .ENTRY_T (entry_t),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_accept),
        .pop   (disp.out_valid & disp.out_ready),
        .wdata (w_push_entry),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (disp.count)
    );

    assign disp.req_ready = w_grant;
    assign disp.out_valid = ~w_empty;
    assign disp.out_src   = w_head.src;
    assign disp.out_seq   = w_head.seq;
    assign disp.out_msg   = w_head.msg;

endmodule
`default_nettype wire

// File: tb/tb_disp_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_disp_arbiter
//  Description : Scoreboard bench for disp_arbiter (N_REQ=4, SEQ_W=4, DEPTH=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_disp_arbiter;

    localparam int N  = 4;
    localparam int MW = 32;
    localparam int SW = 4;
    localparam int D  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    disp_arbiter_if #(.N_REQ(N), .MSG_W(MW), .SEQ_W(SW), .DEPTH(D)) dif ();

    disp_arbiter #(.N_REQ(N), .MSG_W(MW), .SEQ_W(SW), .DEPTH(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .disp  (dif.slave)
    );

    typedef struct packed {
        logic [1:0]    src;
        logic [SW-1:0] seq;
        logic [MW-1:0] msg;
    } exp_t;

    exp_t          sb_q[$];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    logic [SW-1:0] exp_seq = '0;

    function automatic logic [31:0] mk_msg(input int src, input int c);
        return {src[3:0], 12'h5A5, c[15:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_msgs();
        for (int i = 0; i < N; i++) dif.req_msg[i] = mk_msg(i, cyc);
    endtask

    // One cycle: expect grant g (-1 = none), record it, then advance past the edge.
    task automatic step(input int g);
        logic [N-1:0] er;
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        @(negedge clk);
        chk("req_ready", 64'(dif.req_ready), 64'(er));
        if (g >= 0) begin
            sb_q.push_back(exp_t'{src: 2'(g), seq: exp_seq, msg: mk_msg(g, cyc)});
            exp_seq++;
        end
        @(posedge clk);
        #1;
        cyc++;
        drive_msgs();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
            drive_msgs();
        end
    endtask

    exp_t act_e;
    exp_t exp_e;
    exp_t prev_head;
    logic prev_stall = 1'b0;

    always @(negedge clk) begin
        act_e = exp_t'{src: dif.out_src, seq: dif.out_seq, msg: dif.out_msg};
        if (rst_n) begin
            if (prev_stall && dif.out_valid) chk("stall_hold", 64'(act_e), 64'(prev_head));
            if (dif.out_valid && dif.out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("pop_vs_scoreboard", 64'(sb_q.size()), 64'd1);
                end else begin
                    exp_e = sb_q.pop_front();
                    chk("out_entry", 64'(act_e), 64'(exp_e));
                end
            end
            prev_stall = dif.out_valid && !dif.out_ready;
            prev_head  = act_e;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        dif.en_mask   = '1;
        dif.req_valid = '1;
        dif.out_ready = 1'b0;
        drive_msgs();
        #12;
        chk("rst_req_ready", 64'(dif.req_ready), 64'd0);
        chk("rst_out_valid", 64'(dif.out_valid), 64'd0);
        chk("rst_count",     64'(dif.count),     64'd0);
        chk("rst_out_src",   64'(dif.out_src),   64'd0);
        chk("rst_out_seq",   64'(dif.out_seq),   64'd0);
        chk("rst_out_msg",   64'(dif.out_msg),   64'd0);
        dif.req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Round-robin over all four sources.
        dif.en_mask   = '1;
        dif.req_valid = '1;
        dif.out_ready = 1'b1;
        step(0);
        chk("latency_out_valid", 64'(dif.out_valid), 64'd1);
        step(1); step(2); step(3); step(0);

        // Masked sources 0 and 2 never granted.
        dif.en_mask = 4'b1010;
        step(1); step(3); step(1); step(3);
        dif.req_valid = '0;
        idle(2);
        chk("drain_count", 64'(dif.count), 64'd0);

        // Full backpressure from a single source.
        dif.en_mask   = '1;
        dif.req_valid = 4'b0100;
        dif.out_ready = 1'b0;
        step(2); step(2); step(2); step(2);
        chk("full_count", 64'(dif.count), 64'd4);
        chk("full_ready", 64'(dif.req_ready), 64'd0);
        dif.out_ready = 1'b1;
        step(-1);
        dif.out_ready = 1'b0;
        chk("after_pop_count", 64'(dif.count), 64'd3);
        step(2);
        chk("refill_count", 64'(dif.count), 64'd4);
        step(-1);
        dif.req_valid = '0;
        dif.out_ready = 1'b1;
        idle(6);
        chk("full_drain_count", 64'(dif.count), 64'd0);

        // Reset with three entries queued.
        dif.out_ready = 1'b0;
        dif.req_valid = 4'b0001;
        step(0); step(0); step(0);
        dif.req_valid = '0;
        chk("pre_reset_count", 64'(dif.count), 64'd3);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(dif.out_valid), 64'd0);
        chk("midrst_count",     64'(dif.count),     64'd0);
        sb_q.delete();
        exp_seq = '0;
        #1;
        rst_n = 1'b1;
        dif.out_ready = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        drive_msgs();

        // First grant after reset from source 0 with seq 0; run through seq wrap.
        dif.req_valid = '1;
        for (int k = 0; k < 18; k++) step(k % 4);
        dif.req_valid = '0;
        idle(3);
        chk("wrap_drain_count", 64'(dif.count), 64'd0);

        // Stall stability under random sink backpressure.
        dif.out_ready = 1'b0;
        dif.req_valid = 4'b0010;
        step(1); step(1); step(1); step(1);
        dif.req_valid = '0;
        chk("stall_fill_count", 64'(dif.count), 64'd4);
        repeat (40) begin
            dif.out_ready = 1'($urandom_range(0, 1));
            idle(1);
        end
        dif.out_ready = 1'b1;
        idle(6);
        chk("sb_empty",    64'(sb_q.size()), 64'd0);
        chk("final_count", 64'(dif.count),   64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
